// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional macro IFQ_BYPASS_EN: an empty-FIFO response is presented to the core in the same cycle.
module ifetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] fetch_pc, rsp_pc, redir_pc;
  logic [DATA_WIDTH-1:0] mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count, outstanding, drop, rsp_cnt;
  logic [CW:0]           inflight;
  logic                  req_fire, rsp_take, push, pop, bypass, head_vld;

  assign redir_pc = redirect_pc & ~DATA_WIDTH'(3);
  assign inflight = {1'b0, outstanding} + {1'b0, count};
  assign rsp_cnt  = CW'(imem_rsp_valid);

  assign imem_req_valid = !RST && !redirect_valid && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

`ifdef IFQ_BYPASS_EN
  assign bypass = (count == '0) && (drop == '0) && imem_rsp_valid && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  // A taken response is delivered to the core: either pushed, or consumed directly via bypass.
  assign rsp_take = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign push     = rsp_take && !(bypass && out_ready);
  assign head_vld = (count != '0);
  assign pop      = head_vld && out_ready && !redirect_valid;

  assign out_valid = head_vld || bypass;
  assign out_instr = head_vld ? mem_instr[rd_ptr] : (bypass ? imem_rsp_data : '0);
  assign out_pc    = head_vld ? mem_pc[rd_ptr]    : (bypass ? rsp_pc        : '0);

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_instr[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]    <= rsp_pc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (redirect_valid) begin
      // outstanding is kept; the stale responses still in flight are eaten through drop.
      fetch_pc    <= redir_pc;
      rsp_pc      <= redir_pc;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - rsp_cnt;
      drop        <= outstanding - rsp_cnt;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + DATA_WIDTH'(4);
      if (rsp_take) rsp_pc <= rsp_pc + DATA_WIDTH'(4);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      outstanding <= outstanding + CW'(req_fire) - rsp_cnt;
      count       <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: in-order memory model, expected-output queue, directed scenarios.
module tb_ifetch_queue;
  localparam int DW = 32;
`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          imem_req_valid, imem_req_ready = 1'b0;
  logic [DW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          redirect_valid = 1'b0;
  logic [DW-1:0] redirect_pc = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [DW-1:0] out_instr, out_pc;

  ifetch_queue #(.DATA_WIDTH(DW), .DEPTH(4), .RESET_PC('0)) dut (
    .CLK(CLK), .RST(RST),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [DW-1:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [DW-1:0] pc; logic [DW-1:0] instr; } exp_t;

  mreq_t         pend[$];
  exp_t          sb[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] req_log[$];
  int            n_tests = 0, n_fail = 0;
  int            cyc = 0, epoch = 0, lat = 1, nreq = 0, npop = 0;
  logic [DW-1:0] exp_fetch = '0;
  logic          redir_now = 1'b0;
  logic [DW-1:0] redir_target = '0;
  logic          last_ov, last_rsp;

  function automatic logic [DW-1:0] mdata(input logic [DW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, settle, account handshakes in the models, advance to posedge+1.
  task automatic step();
    mreq_t m;
    exp_t  e;
    redirect_valid = redir_now;
    redirect_pc    = redir_target;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    last_rsp       = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      m = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mdata(m.addr);
      last_rsp       = 1'b1;
      if (!redir_now && m.epoch == epoch) sb.push_back('{m.addr, mdata(m.addr)});
    end
    #1;
    last_ov = out_valid;
    if (redir_now) chk("redir_req_block", {31'b0, imem_req_valid}, 32'd0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_fetch);
      pend.push_back('{exp_fetch, epoch, cyc + lat});
      req_log.push_back(exp_fetch);
      exp_fetch += 4;
      nreq++;
    end
    if (out_valid && out_ready && !redir_now) begin
      if (sb.size() == 0) chk("out_unexpected", out_pc, 32'hDEAD_BEEF);
      else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
      end
      hist.push_back(out_pc);
      npop++;
    end
    if (redir_now) begin
      epoch++;
      sb.delete();
      hist.delete();
      req_log.delete();
      exp_fetch = redir_target & ~32'h3;
      redir_now = 1'b0;
    end
    @(posedge CLK); #1;
    cyc++;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge CLK); #1;
    cyc++;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    RST = 1'b0;
    pend.delete(); sb.delete(); hist.delete(); req_log.delete();
    epoch++;
    exp_fetch = '0;
    #1;
    chk("rst_rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    int n0, n1;
    repeat (2) @(posedge CLK);
    #1;

    // Stream with 1-cycle memory
    do_reset();
    lat = 1; out_ready = 1'b1;
    step(); step();
    chk("first_rsp_seen", {31'b0, last_rsp}, 32'd1);
    chk("bypass_same_cycle", {31'b0, last_ov}, {31'b0, BYP});
    repeat (5) step();
    n0 = npop;
    repeat (10) step();
    chk("stream_rate", npop - n0, 32'd10);
    chk("stream_pc0", hist[0], 32'h0);
    chk("stream_pc2", hist[2], 32'h8);

    // Back-pressure
    do_reset();
    lat = 1; out_ready = 1'b0;
    n0 = nreq;
    repeat (12) step();
    chk("bp_reqs", nreq - n0, 32'd4);
    chk("bp_stall", {31'b0, imem_req_valid}, 32'd0);
    out_ready = 1'b1;
    n1 = npop;
    for (int i = 0; i < 20 && (npop - n1 < 4 || req_log.size() < 5); i++) step();
    chk("bp_drained", npop - n1, 32'd4);
    if (hist.size() >= 4) chk("bp_order3", hist[3], 32'hC);
    else chk("bp_order3_tmo", hist.size(), 32'd4);
    if (req_log.size() >= 5) chk("bp_resume", req_log[4], 32'h10);
    else chk("bp_resume_tmo", req_log.size(), 32'd5);

    // Redirect with 3 in flight, 3-cycle memory
    do_reset();
    lat = 3; out_ready = 1'b1;
    for (int i = 0; i < 10 && pend.size() < 3; i++) step();
    chk("r3_inflight", pend.size(), 32'd3);
    redir_target = 32'h1003; redir_now = 1'b1;
    step();
    for (int i = 0; i < 30 && hist.size() < 2; i++) step();
    if (hist.size() >= 2) begin
      chk("r3_first_out", hist[0], 32'h1000);
      chk("r3_first_req", req_log[0], 32'h1000);
    end else chk("r3_tmo", hist.size(), 32'd2);

    // Redirect coinciding with response and pop
    lat = 1;
    repeat (8) step();
    chk("rc_busy", {31'b0, out_valid}, 32'd1);
    redir_target = 32'h200; redir_now = 1'b1;
    step();
    chk("rc_flushed", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 20 && hist.size() < 2; i++) step();
    if (hist.size() >= 2) chk("rc_first_out", hist[0], 32'h200);
    else chk("rc_tmo", hist.size(), 32'd2);

    // Address wrap
    redir_target = 32'hFFFF_FFF8; redir_now = 1'b1;
    step();
    for (int i = 0; i < 20 && hist.size() < 3; i++) step();
    if (hist.size() >= 3) begin
      chk("wrap0", hist[0], 32'hFFFF_FFF8);
      chk("wrap1", hist[1], 32'hFFFF_FFFC);
      chk("wrap2", hist[2], 32'h0000_0000);
    end else chk("wrap_tmo", hist.size(), 32'd3);

    // Reset mid-operation: 2 buffered, 2 outstanding
    do_reset();
    lat = 2; out_ready = 1'b0;
    for (int i = 0; i < 20 && !(sb.size() == 2 && pend.size() == 2); i++) step();
    chk("mid_state_sb", sb.size(), 32'd2);
    chk("mid_state_pend", pend.size(), 32'd2);
    chk("mid_busy", {31'b0, out_valid}, 32'd1);
    do_reset();
    lat = 1; out_ready = 1'b1;
    step(); step();
    chk("mid_bypass", {31'b0, last_ov}, {31'b0, BYP});
    for (int i = 0; i < 10 && hist.size() < 2; i++) step();
    if (hist.size() >= 2) chk("mid_restart_pc", hist[0], 32'h0);
    else chk("mid_tmo", hist.size(), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
